// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types, default constants and duty saturation for the PWM modulator
// Contents:
//   pwm_state_e  gate FSM state (off, high-side on, low-side on, dead gap)
//   PWM_*        default parameter values for the modulator
//   sat()        clamps a duty request to the PWM period
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DEAD = 2'd3
    } pwm_state_e;

    localparam int PWM_PERIOD = 64;
    localparam int PWM_DEAD   = 2;
    localparam int PWM_DUTY_W = 7;

    // min(duty, period): a request longer than the period means "always high".
    function automatic logic [31:0] sat(input logic [31:0] duty, input int period);
        logic [31:0] p;
        p = 32'(period);
        return (duty > p) ? p : duty;
    endfunction

endpackage

// File: rtl/pwm_deadtime_fsm.sv
// rtl/pwm_deadtime_fsm.sv - complementary gate FSM with dead-time insertion
// Ports:
//   sysclk  in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   run control; low forces OFF on the next edge
//   raw     in   uncompensated PWM level (high-side requested)
//   pwm_hi  out  high-side gate
//   pwm_lo  out  low-side gate
module pwm_deadtime_fsm
    import pwm_pkg::*;
#(
    parameter int DEAD = PWM_DEAD
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic enable,
    input  logic raw,
    output logic pwm_hi,
    output logic pwm_lo
);

    // The counter is loaded with DEAD-1 on entry, so DEAD cycles are spent
    // in ST_DEAD before the next gate is allowed on.
    localparam logic [3:0] DCNT_LOAD = 4'(DEAD - 1);

    pwm_state_e state;
    pwm_state_e state_next;
    logic [3:0] dcnt;
    logic [3:0] dcnt_next;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
            dcnt  <= '0;
        end else begin
            state <= state_next;
            dcnt  <= dcnt_next;
        end
    end

    always_comb begin
        state_next = state;
        dcnt_next  = dcnt;
        if (!enable) begin
            // Stop wins over everything: no pulse is allowed to complete.
            state_next = ST_OFF;
            dcnt_next  = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next = ST_DEAD;
                    dcnt_next  = DCNT_LOAD;
                end
                ST_HI: begin
                    if (!raw) begin
                        state_next = ST_DEAD;
                        dcnt_next  = DCNT_LOAD;
                    end
                end
                ST_LO: begin
                    if (raw) begin
                        state_next = ST_DEAD;
                        dcnt_next  = DCNT_LOAD;
                    end
                end
                ST_DEAD: begin
                    // Decide the side only at the end of the gap, so a pulse
                    // shorter than the gap is swallowed rather than emitted.
                    if (dcnt == 4'd0) begin
                        state_next = raw ? ST_HI : ST_LO;
                    end else begin
                        dcnt_next = dcnt - 4'd1;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    dcnt_next  = '0;
                end
            endcase
        end
    end

    // Moore outputs decoded from a single state register: never both high.
    assign pwm_hi = (state == ST_HI);
    assign pwm_lo = (state == ST_LO);

endmodule

// File: rtl/pwm_deadtime_modulator.sv
// rtl/pwm_deadtime_modulator.sv - double-buffered PWM modulator with complementary dead-time outputs
// Ports:
//   sysclk       in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run control; low turns both gates off
//   duty_in      in   requested high time in counts, saturated to PERIOD
//   pwm_hi       out  high-side gate
//   pwm_lo       out  low-side gate
//   load_strobe  out  high in the cycle where duty_in is sampled into duty_active
//   duty_active  out  saturated duty currently being modulated
module pwm_deadtime_modulator
    import pwm_pkg::*;
#(
    parameter int DUTY_W = PWM_DUTY_W,
    parameter int PERIOD = PWM_PERIOD,
    parameter int DEAD   = PWM_DEAD
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_in,
    output logic              pwm_hi,
    output logic              pwm_lo,
    output logic              load_strobe,
    output logic [DUTY_W-1:0] duty_active
);

    localparam int              CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic [DUTY_W-1:0] duty_sat;
    logic              raw;

    assign wrap        = (cnt == CNT_LAST);
    assign load_strobe = enable && wrap;
    assign duty_sat    = DUTY_W'(sat(32'(duty_in), PERIOD));

    // DUTY_W is wider than the counter, so the zero-extended compare is exact;
    // duty_active == PERIOD keeps raw high for the whole period.
    assign raw = (DUTY_W'(cnt) < duty_active);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            duty_active <= '0;
        end else begin
            if (!enable || wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // While stopped the buffer tracks the input, so the first period
            // after enable already uses the latest request. While running it
            // only changes at the period boundary.
            if (!enable || wrap) begin
                duty_active <= duty_sat;
            end
        end
    end

    pwm_deadtime_fsm #(
        .DEAD(DEAD)
    ) u_fsm (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .enable(enable),
        .raw   (raw),
        .pwm_hi(pwm_hi),
        .pwm_lo(pwm_lo)
    );

endmodule
